// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//
// Pipeline MEM stage. Non-memory instructions from EX are registered straight
// through to WB with one cycle of latency. Loads and stores (LDW, LDB, STW,
// STB) are run on a req/ack data-memory port. A stall is raised towards EX/DE
// while an access is outstanding. An access that gets no acknowledge within
// TIMEOUT cycles is abandoned and reported to WB as a fault.
//
// All state updates on the falling edge of I_CLOCK. I_RESET is asynchronous
// and active high.
//
// Ports
//   I_CLOCK, I_RESET         clock (falling-edge active) and async reset
//   I_EX_Valid ... I_MDRValue  instruction fields handed over by EX
//   O_DMEM_Req/WEn/Addr/WData/BE, I_DMEM_Ack/RData   data-memory port
//   O_MEM_Valid ... O_MemFault  registered instruction fields towards WB
//   O_MEMStallSignal         combinational; EX/DE hold their outputs while high
// ---------------------------------------------------------------------------
module mem_access_stage #(
  parameter int ADDR_WIDTH   = 11,
  parameter int TIMEOUT      = 16,
  parameter int OPCODE_WIDTH = 8,
  parameter int REG_WIDTH    = 16,
  parameter logic [OPCODE_WIDTH-1:0] OP_LDW = OPCODE_WIDTH'(8'h20),
  parameter logic [OPCODE_WIDTH-1:0] OP_LDB = OPCODE_WIDTH'(8'h21),
  parameter logic [OPCODE_WIDTH-1:0] OP_STW = OPCODE_WIDTH'(8'h22),
  parameter logic [OPCODE_WIDTH-1:0] OP_STB = OPCODE_WIDTH'(8'h23)
) (
  input  logic                    I_CLOCK,
  input  logic                    I_RESET,
  input  logic                    I_EX_Valid,
  input  logic [OPCODE_WIDTH-1:0] I_Opcode,
  input  logic [3:0]              I_DestRegIdx,
  input  logic [REG_WIDTH-1:0]    I_DestValue,
  input  logic [2:0]              I_CCValue,
  input  logic                    I_RegWEn,
  input  logic                    I_CCWEn,
  input  logic [REG_WIDTH-1:0]    I_MARValue,
  input  logic [REG_WIDTH-1:0]    I_MDRValue,
  output logic                    O_DMEM_Req,
  output logic                    O_DMEM_WEn,
  output logic [ADDR_WIDTH-1:0]   O_DMEM_Addr,
  output logic [REG_WIDTH-1:0]    O_DMEM_WData,
  output logic [1:0]              O_DMEM_BE,
  input  logic                    I_DMEM_Ack,
  input  logic [REG_WIDTH-1:0]    I_DMEM_RData,
  output logic                    O_MEM_Valid,
  output logic [OPCODE_WIDTH-1:0] O_Opcode,
  output logic [3:0]              O_DestRegIdx,
  output logic [REG_WIDTH-1:0]    O_DestValue,
  output logic [2:0]              O_CCValue,
  output logic                    O_RegWEn,
  output logic                    O_CCWEn,
  output logic                    O_MemFault,
  output logic                    O_MEMStallSignal
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  logic [0:0]              state;
  logic [CNT_W-1:0]        count;

  // Instruction fields captured when an access starts; EX is free to move on
  // once the stall drops, so WB must be fed from these copies.
  logic [OPCODE_WIDTH-1:0] lat_op;
  logic [3:0]              lat_dest;
  logic [2:0]              lat_cc;
  logic                    lat_byte_sel;

  // Memory-port drive registers, stable for the whole access.
  logic                    bus_wen;
  logic [ADDR_WIDTH-1:0]   bus_addr;
  logic [REG_WIDTH-1:0]    bus_wdata;
  logic [1:0]              bus_be;

  logic is_load;
  logic is_store;
  logic is_word;
  logic is_mem;
  logic lat_is_load;
  logic lat_is_word;
  logic timeout;
  logic [REG_WIDTH-1:0] load_value;

  // MAR bits above the word address do not reach this memory.
  logic unused_mar_bits;
  assign unused_mar_bits = ^I_MARValue[REG_WIDTH-1:ADDR_WIDTH+1];

  // Opcode decode for the incoming instruction and for the latched one.
  assign is_load     = (I_Opcode == OP_LDW) || (I_Opcode == OP_LDB);
  assign is_store    = (I_Opcode == OP_STW) || (I_Opcode == OP_STB);
  assign is_word     = (I_Opcode == OP_LDW) || (I_Opcode == OP_STW);
  assign is_mem      = is_load || is_store;
  assign lat_is_load = (lat_op == OP_LDW) || (lat_op == OP_LDB);
  assign lat_is_word = (lat_op == OP_LDW) || (lat_op == OP_STW);

  // The last permitted access cycle; if no ack arrives here the access is
  // dropped at the next edge.
  assign timeout = (count == CNT_W'(TIMEOUT - 1));

  // Byte loads return the addressed lane zero-extended.
  assign load_value = lat_is_word ? I_DMEM_RData :
                      lat_byte_sel ? {{(REG_WIDTH-8){1'b0}}, I_DMEM_RData[15:8]} :
                                     {{(REG_WIDTH-8){1'b0}}, I_DMEM_RData[7:0]};

  // Req comes straight from the state register so that an async reset
  // withdraws it immediately.
  assign O_DMEM_Req   = (state == ST_ACCESS);
  assign O_DMEM_WEn   = bus_wen;
  assign O_DMEM_Addr  = bus_addr;
  assign O_DMEM_WData = bus_wdata;
  assign O_DMEM_BE    = bus_be;

  // The stall is raised in the very cycle a memory op shows up so EX keeps it
  // steady while it is captured, and released in the ack/timeout cycle so EX
  // can advance on that same edge.
  assign O_MEMStallSignal = ((state == ST_IDLE) && I_EX_Valid && is_mem) ||
                            ((state == ST_ACCESS) && !I_DMEM_Ack && !timeout);

  // Main sequencer: pass-through in IDLE, access tracking in ACCESS, and the
  // WB-bound output registers.
  always_ff @(negedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      state        <= ST_IDLE;
      count        <= '0;
      lat_op       <= '0;
      lat_dest     <= '0;
      lat_cc       <= '0;
      lat_byte_sel <= 1'b0;
      bus_wen      <= 1'b0;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      bus_be       <= '0;
      O_MEM_Valid  <= 1'b0;
      O_Opcode     <= '0;
      O_DestRegIdx <= '0;
      O_DestValue  <= '0;
      O_CCValue    <= '0;
      O_RegWEn     <= 1'b0;
      O_CCWEn      <= 1'b0;
      O_MemFault   <= 1'b0;
    end else begin
      O_MemFault <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (I_EX_Valid && is_mem) begin
            state        <= ST_ACCESS;
            count        <= '0;
            lat_op       <= I_Opcode;
            lat_dest     <= I_DestRegIdx;
            lat_cc       <= I_CCValue;
            lat_byte_sel <= I_MARValue[0];
            bus_wen      <= is_store;
            bus_addr     <= I_MARValue[ADDR_WIDTH:1];
            // Byte stores replicate the data into both lanes; BE picks one.
            bus_wdata    <= is_word ? I_MDRValue : {I_MDRValue[7:0], I_MDRValue[7:0]};
            bus_be       <= is_word ? 2'b11 : (I_MARValue[0] ? 2'b10 : 2'b01);
            O_MEM_Valid  <= 1'b0;
            O_RegWEn     <= 1'b0;
            O_CCWEn      <= 1'b0;
          end else begin
            O_MEM_Valid  <= I_EX_Valid;
            O_Opcode     <= I_Opcode;
            O_DestRegIdx <= I_DestRegIdx;
            O_DestValue  <= I_DestValue;
            O_CCValue    <= I_CCValue;
            O_RegWEn     <= I_EX_Valid && I_RegWEn;
            O_CCWEn      <= I_EX_Valid && I_CCWEn;
          end
        end
        default: begin
          O_Opcode     <= lat_op;
          O_DestRegIdx <= lat_dest;
          O_CCValue    <= lat_cc;
          O_CCWEn      <= 1'b0;
          if (I_DMEM_Ack) begin
            state       <= ST_IDLE;
            count       <= '0;
            O_MEM_Valid <= 1'b1;
            O_DestValue <= lat_is_load ? load_value : '0;
            O_RegWEn    <= lat_is_load;
          end else if (timeout) begin
            state       <= ST_IDLE;
            count       <= '0;
            O_MEM_Valid <= 1'b1;
            O_MemFault  <= 1'b1;
            O_DestValue <= '0;
            O_RegWEn    <= 1'b0;
          end else begin
            count       <= count + 1'b1;
            O_MEM_Valid <= 1'b0;
            O_RegWEn    <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_access_stage
//
// Directed and randomised instruction sequences for mem_access_stage. The
// bench plays the data memory itself, holding a word array that is updated
// by the load/store rules, and predicts every WB-side result from it.
// ---------------------------------------------------------------------------
module tb_mem_access_stage;

  localparam int TIMEOUT = 16;
  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_LDW = 8'h20;
  localparam logic [7:0] OP_LDB = 8'h21;
  localparam logic [7:0] OP_STW = 8'h22;
  localparam logic [7:0] OP_STB = 8'h23;

  logic        clock;
  logic        reset;
  logic        ex_valid;
  logic [7:0]  opcode;
  logic [3:0]  dest_idx;
  logic [15:0] dest_value;
  logic [2:0]  cc_value;
  logic        reg_wen;
  logic        cc_wen;
  logic [15:0] mar;
  logic [15:0] mdr;
  logic        dmem_req;
  logic        dmem_wen;
  logic [10:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic [1:0]  dmem_be;
  logic        dmem_ack;
  logic [15:0] dmem_rdata;
  logic        mem_valid;
  logic [7:0]  out_opcode;
  logic [3:0]  out_dest_idx;
  logic [15:0] out_dest_value;
  logic [2:0]  out_cc_value;
  logic        out_reg_wen;
  logic        out_cc_wen;
  logic        mem_fault;
  logic        stall;

  int check_count = 0;
  int fail_count  = 0;

  logic [15:0] ref_mem [0:2047];

  mem_access_stage #(
    .ADDR_WIDTH(11), .TIMEOUT(TIMEOUT), .OPCODE_WIDTH(8), .REG_WIDTH(16),
    .OP_LDW(OP_LDW), .OP_LDB(OP_LDB), .OP_STW(OP_STW), .OP_STB(OP_STB)
  ) dut (
    .I_CLOCK(clock), .I_RESET(reset), .I_EX_Valid(ex_valid), .I_Opcode(opcode),
    .I_DestRegIdx(dest_idx), .I_DestValue(dest_value), .I_CCValue(cc_value),
    .I_RegWEn(reg_wen), .I_CCWEn(cc_wen), .I_MARValue(mar), .I_MDRValue(mdr),
    .O_DMEM_Req(dmem_req), .O_DMEM_WEn(dmem_wen), .O_DMEM_Addr(dmem_addr),
    .O_DMEM_WData(dmem_wdata), .O_DMEM_BE(dmem_be), .I_DMEM_Ack(dmem_ack),
    .I_DMEM_RData(dmem_rdata), .O_MEM_Valid(mem_valid), .O_Opcode(out_opcode),
    .O_DestRegIdx(out_dest_idx), .O_DestValue(out_dest_value),
    .O_CCValue(out_cc_value), .O_RegWEn(out_reg_wen), .O_CCWEn(out_cc_wen),
    .O_MemFault(mem_fault), .O_MEMStallSignal(stall)
  );

  // DUT acts on the falling edge; the bench samples and drives on the rising edge.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Safety net against a bench that somehow stops advancing.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    check_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One cycle with no valid instruction; garbage fields must not leak to WB or memory.
  task automatic idle_cycle();
    ex_valid   = 1'b0;
    opcode     = ($urandom_range(0, 1) == 0) ? OP_LDW : 8'($urandom);
    reg_wen    = 1'b1;
    cc_wen     = 1'b1;
    mar        = 16'($urandom);
    #1;
    check_output("idle_stall", stall, 0);
    @(posedge clock);
    check_output("idle_valid", mem_valid, 0);
    check_output("idle_regwen", out_reg_wen, 0);
    check_output("idle_ccwen", out_cc_wen, 0);
    check_output("idle_req", dmem_req, 0);
    check_output("idle_fault", mem_fault, 0);
  endtask

  // Presents one instruction, serves the memory side with an ack after
  // wait_cycles unacknowledged cycles (never, if wait_cycles >= TIMEOUT), and
  // checks the result handed to WB against the word-array model.
  task automatic apply_stimulus(input logic [7:0] op, input logic [3:0] dst,
                                input logic [15:0] dval, input logic [2:0] cc,
                                input logic rwe, input logic cwe,
                                input logic [15:0] mar_v, input logic [15:0] mdr_v,
                                input int wait_cycles);
    logic        ld;
    logic        st;
    logic        word;
    logic        fault;
    logic [10:0] word_addr;
    logic [15:0] exp_value;
    logic [15:0] exp_wdata;
    logic [1:0]  exp_be;
    int          k;
    ld        = (op == OP_LDW) || (op == OP_LDB);
    st        = (op == OP_STW) || (op == OP_STB);
    word      = (op == OP_LDW) || (op == OP_STW);
    word_addr = mar_v[11:1];
    fault     = (wait_cycles >= TIMEOUT);
    exp_wdata = word ? mdr_v : {mdr_v[7:0], mdr_v[7:0]};
    exp_be    = word ? 2'b11 : (mar_v[0] ? 2'b10 : 2'b01);
    if (op == OP_LDW) exp_value = ref_mem[word_addr];
    else if (mar_v[0]) exp_value = {8'h00, ref_mem[word_addr][15:8]};
    else exp_value = {8'h00, ref_mem[word_addr][7:0]};

    ex_valid   = 1'b1;
    opcode     = op;
    dest_idx   = dst;
    dest_value = dval;
    cc_value   = cc;
    reg_wen    = rwe;
    cc_wen     = cwe;
    mar        = mar_v;
    mdr        = mdr_v;
    #1;
    check_output("issue_stall", stall, 32'(ld || st));

    if (!(ld || st)) begin
      @(posedge clock);
      check_output("pass_valid", mem_valid, 1);
      check_output("pass_opcode", out_opcode, op);
      check_output("pass_dest", out_dest_idx, dst);
      check_output("pass_value", out_dest_value, dval);
      check_output("pass_cc", out_cc_value, cc);
      check_output("pass_regwen", out_reg_wen, rwe);
      check_output("pass_ccwen", out_cc_wen, cwe);
      check_output("pass_req", dmem_req, 0);
      check_output("pass_fault", mem_fault, 0);
      ex_valid = 1'b0;
      return;
    end

    k = 0;
    while (k < TIMEOUT) begin
      @(posedge clock);
      check_output("acc_req", dmem_req, 1);
      check_output("acc_addr", dmem_addr, word_addr);
      check_output("acc_wen", dmem_wen, st);
      check_output("acc_valid", mem_valid, 0);
      if (st) begin
        check_output("acc_be", dmem_be, exp_be);
        check_output("acc_wdata", dmem_wdata, exp_wdata);
      end
      if (k == wait_cycles) begin
        dmem_ack   = 1'b1;
        dmem_rdata = ref_mem[word_addr];
        if (op == OP_STW) ref_mem[word_addr] = mdr_v;
        else if (op == OP_STB && mar_v[0]) ref_mem[word_addr][15:8] = mdr_v[7:0];
        else if (op == OP_STB) ref_mem[word_addr][7:0] = mdr_v[7:0];
      end else begin
        dmem_ack   = 1'b0;
        dmem_rdata = 16'($urandom);
      end
      #1;
      check_output("acc_stall", stall, 32'(k != wait_cycles && k != TIMEOUT - 1));
      if (k == wait_cycles || k == TIMEOUT - 1) break;
      k++;
    end
    ex_valid = 1'b0;

    @(posedge clock);
    dmem_ack   = 1'b0;
    dmem_rdata = 16'($urandom);
    check_output("done_valid", mem_valid, 1);
    check_output("done_fault", mem_fault, fault);
    check_output("done_regwen", out_reg_wen, 32'(ld && !fault));
    check_output("done_ccwen", out_cc_wen, 0);
    check_output("done_opcode", out_opcode, op);
    check_output("done_dest", out_dest_idx, dst);
    check_output("done_cc", out_cc_value, cc);
    check_output("done_req", dmem_req, 0);
    if (ld && !fault) check_output("done_load_value", out_dest_value, exp_value);
  endtask

  // Directed sequence followed by a randomised instruction stream.
  initial begin
    logic [7:0] ops [0:5];
    ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_LDW;
    ops[3] = OP_LDB; ops[4] = OP_STW; ops[5] = OP_STB;
    for (int i = 0; i < 2048; i++) ref_mem[i] = 16'($urandom);

    reset = 1'b1; ex_valid = 1'b0; opcode = '0; dest_idx = '0; dest_value = '0;
    cc_value = '0; reg_wen = 1'b0; cc_wen = 1'b0; mar = '0; mdr = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    @(posedge clock);
    @(posedge clock);
    check_output("rst_req", dmem_req, 0);
    check_output("rst_valid", mem_valid, 0);
    check_output("rst_value", out_dest_value, 0);
    check_output("rst_regwen", out_reg_wen, 0);
    check_output("rst_fault", mem_fault, 0);
    check_output("rst_stall", stall, 0);
    reset = 1'b0;
    @(posedge clock);

    // ADD pass-through, then the reference STW and LDB cases.
    apply_stimulus(OP_ADD, 4'd3, 16'h0005, 3'b001, 1'b1, 1'b1, 16'h0000, 16'h0000, 0);
    apply_stimulus(OP_STW, 4'd1, 16'h0000, 3'b010, 1'b1, 1'b1, 16'h0010, 16'hBEEF, 3);
    ref_mem[11'h008] = 16'hA57C;
    apply_stimulus(OP_LDB, 4'd2, 16'h0000, 3'b100, 1'b0, 1'b1, 16'h0011, 16'h0000, 0);
    apply_stimulus(OP_LDW, 4'd4, 16'h0000, 3'b000, 1'b1, 1'b0, 16'h0010, 16'h0000, 1);
    idle_cycle();

    // LDW that never gets an ack runs into the timeout; the fault is one pulse.
    apply_stimulus(OP_LDW, 4'd5, 16'h0000, 3'b011, 1'b1, 1'b0, 16'h0100, 16'h0000, TIMEOUT + 4);
    idle_cycle();

    // Reset in the second ACCESS cycle abandons the access at once.
    ex_valid = 1'b1; opcode = OP_LDW; dest_idx = 4'd6; reg_wen = 1'b1; mar = 16'h0040;
    @(posedge clock);
    @(posedge clock);
    check_output("mid_req_before", dmem_req, 1);
    reset = 1'b1;
    ex_valid = 1'b0;
    #1;
    check_output("mid_rst_req", dmem_req, 0);
    check_output("mid_rst_addr", dmem_addr, 0);
    check_output("mid_rst_be", dmem_be, 0);
    check_output("mid_rst_valid", mem_valid, 0);
    check_output("mid_rst_regwen", out_reg_wen, 0);
    check_output("mid_rst_stall", stall, 0);
    @(posedge clock);
    reset = 1'b0;
    @(posedge clock);
    apply_stimulus(OP_ADD, 4'd7, 16'h1234, 3'b101, 1'b1, 1'b0, 16'h0000, 16'h0000, 0);

    // Byte store into the hi lane, read back as a word right behind it.
    apply_stimulus(OP_STB, 4'd0, 16'h0000, 3'b000, 1'b1, 1'b1, 16'h0003, 16'h12C3, 2);
    apply_stimulus(OP_LDW, 4'd8, 16'h0000, 3'b000, 1'b0, 1'b0, 16'h0002, 16'h0000, 0);
    check_output("b2b_hi_lane", out_dest_value[15:8], 8'hC3);

    // Ack on the very last permitted cycle wins over the timeout.
    apply_stimulus(OP_LDB, 4'd9, 16'h0000, 3'b000, 1'b1, 1'b1, 16'h0002, 16'h0000, TIMEOUT - 1);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] op;
      int         wait_cycles;
      op = ops[$urandom_range(0, 5)];
      wait_cycles = ($urandom_range(0, 9) == 0) ? TIMEOUT + 1 : $urandom_range(0, 4);
      if ($urandom_range(0, 3) == 0) idle_cycle();
      apply_stimulus(op, 4'($urandom), 16'($urandom), 3'($urandom), 1'($urandom),
                     1'($urandom), {4'h0, 12'($urandom_range(0, 32))}, 16'($urandom),
                     wait_cycles);
    end
    idle_cycle();

    $display("%0d/%0d checks passed", check_count - fail_count, check_count);
    $finish;
  end

endmodule
